// File: rtl/spi_pkg.sv
// Shared SPI definitions: opcodes, default frame geometry and the tx state encoding.
// Used by both the SPI transmitter and the receiver side of the link.
package spi_pkg;

  localparam int         OPCODE_W    = 8;
  localparam logic [7:0] OPCODE_CFG  = 8'h00;
  localparam logic [7:0] OPCODE_RUN  = 8'hff;
  localparam int         DEF_D_WIDTH = 16;
  localparam int         DEF_N_WORDS = 5;

  function automatic int frame_bits(input int n_words, input int d_width);
    return OPCODE_W + n_words * d_width;
  endfunction

  localparam int FRAME_BITS = frame_bits(DEF_N_WORDS, DEF_D_WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2,
    GAP   = 2'd3
  } tx_state_e;

endpackage

// File: rtl/spi_clk_div.sv
// Half-period tick generator: one-cycle enable every CLK_DIV clk_sys cycles while not cleared.
module spi_clk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk_sys,
  input  logic rstb,
  input  logic clear,
  output logic tick
);

  logic [7:0] cnt;

  // Clearing parks the count at zero so the first tick lands CLK_DIV cycles after release.
  assign tick = !clear && (cnt == 8'(CLK_DIV - 1));

  always_ff @(posedge clk_sys or negedge rstb) begin
    if (!rstb) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/spi_master_tx.sv
// SPI mode-0 frame transmitter: captures opcode plus N_WORDS payload words and shifts them out MSB first,
// followed by a cs-low hold and a cs-high gap before the next frame can be accepted.
module spi_master_tx
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int D_WIDTH = 16,
  parameter int N_WORDS = 5
) (
  input  logic                              clk_sys,
  input  logic                              rstb,
  input  logic                              valid,
  output logic                              ready,
  input  logic [7:0]                        opcode_in,
  input  logic [N_WORDS-1:0][D_WIDTH-1:0]   data_in,
  output logic                              clk_mosi,
  output logic                              cs,
  output logic                              spi_mosi,
  output logic                              done
);

  localparam int FRAME_LEN = frame_bits(N_WORDS, D_WIDTH);
  localparam int CNT_W     = $clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_LEN - 1);

  tx_state_e             state, state_n;
  logic [FRAME_LEN-1:0]  shreg, shreg_n;
  logic [CNT_W-1:0]      bit_cnt, bit_cnt_n;
  logic                  clk_mosi_n, cs_n, ready_n, done_n;
  logic                  tick;

  spi_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_div (
    .clk_sys (clk_sys),
    .rstb    (rstb),
    .clear   (state == IDLE),
    .tick    (tick)
  );

  // The serial pin is the shift register MSB itself, so it only moves when the register shifts.
  assign spi_mosi = shreg[FRAME_LEN-1];

  always_ff @(posedge clk_sys or negedge rstb) begin
    if (!rstb) begin
      state    <= IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      clk_mosi <= 1'b0;
      cs       <= 1'b1;
      ready    <= 1'b1;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      shreg    <= shreg_n;
      bit_cnt  <= bit_cnt_n;
      clk_mosi <= clk_mosi_n;
      cs       <= cs_n;
      ready    <= ready_n;
      done     <= done_n;
    end
  end

  always_comb begin
    state_n    = state;
    shreg_n    = shreg;
    bit_cnt_n  = bit_cnt;
    clk_mosi_n = clk_mosi;
    cs_n       = cs;
    ready_n    = ready;
    done_n     = 1'b0;

    unique case (state)
      IDLE: begin
        if (valid && ready) begin
          state_n    = SHIFT;
          shreg_n    = {opcode_in, data_in};
          bit_cnt_n  = '0;
          clk_mosi_n = 1'b0;
          cs_n       = 1'b0;
          ready_n    = 1'b0;
        end
      end

      // Falling half of each bit shifts; after the final bit the zero fill parks the pin low.
      SHIFT: begin
        if (tick) begin
          if (!clk_mosi) begin
            clk_mosi_n = 1'b1;
          end else begin
            clk_mosi_n = 1'b0;
            shreg_n    = {shreg[FRAME_LEN-2:0], 1'b0};
            if (bit_cnt == LAST_BIT) begin
              state_n = HOLD;
            end else begin
              bit_cnt_n = bit_cnt + CNT_W'(1);
            end
          end
        end
      end

      HOLD: begin
        if (tick) begin
          state_n = GAP;
          cs_n    = 1'b1;
        end
      end

      GAP: begin
        if (tick) begin
          state_n   = IDLE;
          ready_n   = 1'b1;
          done_n    = 1'b1;
          bit_cnt_n = '0;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_spi_master_tx.sv
// Directed bench for spi_master_tx at CLK_DIV=2: serialization, timing, back-to-back frames,
// input isolation during a frame and asynchronous reset mid-frame.
module tb_spi_master_tx;
  import spi_pkg::*;

  localparam int CLK_DIV   = 2;
  localparam int D_WIDTH   = 16;
  localparam int N_WORDS   = 5;
  localparam int FB        = 8 + N_WORDS * D_WIDTH;
  localparam int FRAME_CYC = (2 * FB + 2) * CLK_DIV;
  localparam int BOUND     = 2000;

  localparam logic [FB-9:0] D1 = 80'h1234_5678_9ABC_DEF0_0FA0;
  localparam logic [FB-9:0] D2 = 80'hCAFE_0001_8000_7FFF_5A5A;
  localparam logic [FB-9:0] D3 = 80'hFFFF_0000_AAAA_5555_0F0F;
  localparam logic [FB-9:0] D4 = 80'h1111_2222_3333_4444_5555;
  localparam logic [FB-9:0] D5 = 80'hDEAD_BEEF_0123_4567_89AB;
  localparam logic [FB-9:0] D6 = 80'h0F0F_F0F0_A5A5_5A5A_8001;

  logic                            clk_sys = 1'b0;
  logic                            rstb    = 1'b0;
  logic                            valid   = 1'b0;
  logic [7:0]                      opcode_in = 8'h00;
  logic [N_WORDS-1:0][D_WIDTH-1:0] data_in = '0;
  logic                            ready;
  logic                            clk_mosi;
  logic                            cs;
  logic                            spi_mosi;
  logic                            done;

  int               vectors     = 0;
  int               miscompares = 0;
  logic [FB-1:0]    cap         = '0;
  int               edges       = 0;

  spi_master_tx #(
    .CLK_DIV (CLK_DIV),
    .D_WIDTH (D_WIDTH),
    .N_WORDS (N_WORDS)
  ) dut (
    .clk_sys   (clk_sys),
    .rstb      (rstb),
    .valid     (valid),
    .ready     (ready),
    .opcode_in (opcode_in),
    .data_in   (data_in),
    .clk_mosi  (clk_mosi),
    .cs        (cs),
    .spi_mosi  (spi_mosi),
    .done      (done)
  );

  always #5 clk_sys = ~clk_sys;

  // Receiver model: samples the data line on every rising SPI clock edge.
  always @(posedge clk_mosi) begin
    cap   = {cap[FB-2:0], spi_mosi};
    edges = edges + 1;
  end

  task automatic checkOutput(input string tag, input logic [FB-1:0] obs, input logic [FB-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] op, input logic [FB-9:0] data, output int e0);
    int w;
    @(negedge clk_sys);
    opcode_in = op;
    data_in   = data;
    valid     = 1'b1;
    w = 0;
    while (!ready && w < BOUND) begin
      @(negedge clk_sys);
      w++;
    end
    checkOutput("accept_wait", FB'(w < BOUND), FB'(1));
    e0 = edges;
    @(negedge clk_sys);
  endtask

  task automatic waitFrame(output int lat, output int dones, output int cs_hi);
    lat = 0; dones = 0; cs_hi = 0;
    do begin
      @(negedge clk_sys);
      lat++;
      if (done) dones++;
      if (cs) cs_hi++;
    end while (!ready && lat < BOUND);
  endtask

  initial begin
    int e0, lat, dones, cs_hi, w;

    repeat (3) @(negedge clk_sys);
    checkOutput("rst_cs",       FB'(cs),       FB'(1));
    checkOutput("rst_clk_mosi", FB'(clk_mosi), FB'(0));
    checkOutput("rst_mosi",     FB'(spi_mosi), FB'(0));
    checkOutput("rst_ready",    FB'(ready),    FB'(1));
    checkOutput("rst_done",     FB'(done),     FB'(0));
    rstb = 1'b1;

    // Config frame with the reference payload.
    applyStimulus(OPCODE_CFG, D1, e0);
    valid = 1'b0;
    checkOutput("f1_cs_low_at_T",   FB'(cs),       FB'(0));
    checkOutput("f1_clk_low_at_T",  FB'(clk_mosi), FB'(0));
    checkOutput("f1_ready_low_at_T", FB'(ready),   FB'(0));
    waitFrame(lat, dones, cs_hi);
    checkOutput("f1_ready_latency", FB'(lat),        FB'(FRAME_CYC));
    checkOutput("f1_done_pulses",   FB'(dones),      FB'(1));
    checkOutput("f1_cs_high_gap",   FB'(cs_hi),      FB'(CLK_DIV + 1));
    checkOutput("f1_edge_count",    FB'(edges - e0), FB'(FB));
    checkOutput("f1_bits",          cap,             88'h00_1234_5678_9ABC_DEF0_0FA0);
    @(negedge clk_sys);
    checkOutput("f1_done_one_cycle", FB'(done), FB'(0));

    // Inputs disturbed mid-frame must not alter the frame nor start another.
    applyStimulus(8'hA5, D2, e0);
    valid = 1'b0;
    repeat (100) @(negedge clk_sys);
    opcode_in = 8'h5A;
    data_in   = ~D2;
    valid     = 1'b1;
    repeat (50) @(negedge clk_sys);
    valid = 1'b0;
    waitFrame(lat, dones, cs_hi);
    checkOutput("f2_ready_latency", FB'(lat),        FB'(FRAME_CYC - 150));
    checkOutput("f2_edge_count",    FB'(edges - e0), FB'(FB));
    checkOutput("f2_bits",          cap,             {8'hA5, D2});
    repeat (20) @(negedge clk_sys);
    checkOutput("f2_no_second_cs",    FB'(cs),         FB'(1));
    checkOutput("f2_no_second_edges", FB'(edges - e0), FB'(FB));

    // Back-to-back run frames with valid held high.
    applyStimulus(OPCODE_RUN, D3, e0);
    checkOutput("f3_first_bit", FB'(spi_mosi), FB'(1));
    waitFrame(lat, dones, cs_hi);
    checkOutput("f3_ready_latency", FB'(lat),        FB'(FRAME_CYC));
    checkOutput("f3_done_pulses",   FB'(dones),      FB'(1));
    checkOutput("f3_edge_count",    FB'(edges - e0), FB'(FB));
    checkOutput("f3_bits",          cap,             {OPCODE_RUN, D3});
    data_in = D4;
    e0 = edges;
    @(negedge clk_sys);
    checkOutput("b2b_cs_restart", FB'(cs),    FB'(0));
    checkOutput("b2b_cs_high",    FB'(cs_hi), FB'(CLK_DIV + 1));
    valid = 1'b0;
    waitFrame(lat, dones, cs_hi);
    checkOutput("f4_ready_latency", FB'(lat),        FB'(FRAME_CYC));
    checkOutput("f4_done_pulses",   FB'(dones),      FB'(1));
    checkOutput("f4_edge_count",    FB'(edges - e0), FB'(FB));
    checkOutput("f4_bits",          cap,             {OPCODE_RUN, D4});

    // Asynchronous reset at bit 40, then a fresh frame.
    applyStimulus(8'h3C, D5, e0);
    valid = 1'b0;
    w = 0;
    while ((edges - e0) < 40 && w < BOUND) begin
      @(negedge clk_sys);
      w++;
    end
    checkOutput("f5_reached_bit40", FB'(edges - e0), FB'(40));
    rstb = 1'b0;
    #1;
    checkOutput("mid_rst_cs",       FB'(cs),       FB'(1));
    checkOutput("mid_rst_clk_mosi", FB'(clk_mosi), FB'(0));
    checkOutput("mid_rst_mosi",     FB'(spi_mosi), FB'(0));
    checkOutput("mid_rst_ready",    FB'(ready),    FB'(1));
    checkOutput("mid_rst_done",     FB'(done),     FB'(0));
    @(negedge clk_sys);
    rstb = 1'b1;

    applyStimulus(8'hC3, D6, e0);
    valid = 1'b0;
    checkOutput("f6_first_bit", FB'(spi_mosi), FB'(1));
    waitFrame(lat, dones, cs_hi);
    checkOutput("f6_ready_latency", FB'(lat),        FB'(FRAME_CYC));
    checkOutput("f6_done_pulses",   FB'(dones),      FB'(1));
    checkOutput("f6_edge_count",    FB'(edges - e0), FB'(FB));
    checkOutput("f6_bits",          cap,             {8'hC3, D6});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
